// File: rtl/key_repeater_pkg.sv
// Shared key-handling definitions.
// State encoding reused by every key block.
package key_repeater_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_timer.sv
// Hold/repeat interval counter.
// Saturates at the terminal count so it can never wrap.
module key_timer #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] tc,
    output logic                 done
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else if (!done) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

    assign done = (count == tc);

endmodule

// File: rtl/key_repeater.sv
// Key press / auto-repeat / release pulse generator.
// Consumes a debounced level and emits registered event pulses.
module key_repeater
    import key_repeater_pkg::*;
#(
    parameter int CNT_WIDTH    = 24,
    parameter int HOLD_COUNT   = 5000000,
    parameter int REPEAT_COUNT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic       press,
    output logic       release_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [CNT_WIDTH-1:0] HOLD_TC   = CNT_WIDTH'(HOLD_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_COUNT - 1);

    key_state_t           state, state_n;
    logic                 in_q;
    logic                 rise, fall;
    logic                 press_n, rel_n, held_n;
    logic [7:0]           cnt_n;
    logic                 tmr_clr, tmr_done;
    logic [CNT_WIDTH-1:0] tmr_tc;

    assign rise   = in & ~in_q;
    assign fall   = ~in & in_q;
    assign tmr_tc = (state == REPEAT) ? REPEAT_TC : HOLD_TC;

    key_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (tmr_clr),
        .tc  (tmr_tc),
        .done(tmr_done)
    );

    always_comb begin
        state_n = state;
        press_n = 1'b0;
        rel_n   = 1'b0;
        held_n  = held;
        tmr_clr = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (rise) begin
                    state_n = HOLD;
                    press_n = 1'b1;
                end else if (fall) begin
                    rel_n = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                // release takes priority over a coincident expiry
                if (fall) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    held_n  = 1'b0;
                    tmr_clr = 1'b1;
                end else if (tmr_done && in) begin
                    state_n = REPEAT;
                    press_n = 1'b1;
                    held_n  = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                held_n  = 1'b0;
                tmr_clr = 1'b1;
            end
        endcase
        cnt_n = press_n ? press_count + 8'd1 : press_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            in_q          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else if (en) begin
            state         <= state_n;
            in_q          <= in;
            press         <= press_n;
            release_pulse <= rel_n;
            held          <= held_n;
            press_count   <= cnt_n;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end
    end

endmodule
